// File: rtl/axi_master_arbiter_pkg.sv
// Shared constants, requester indices and FSM state type for the AXI master arbiter.
package axi_master_arbiter_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic IFU = 1'b0;
  localparam logic LSU = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RD_IFU,
    RD_LSU,
    WR_LSU
  } arb_state_t;

endpackage

// File: rtl/axi_master_arbiter_rr_arbiter2.sv
// Two-way round-robin picker; the last-grant pointer only moves when both requesters compete.
module rr_arbiter2
  import axi_master_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic rr_last;

  // Pick the lone requester, or the one not served last on a conflict.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = IFU;
    if (&req)
      gnt_idx = ~rr_last;
    else if (req[LSU])
      gnt_idx = LSU;
  end

  // Remember who won the most recent conflict.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rr_last <= IFU;
    else if (en && (&req))
      rr_last <= ~rr_last;
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// Shares one AXI4 master port between the IFU (read-only) and the LSU (read/write),
// granting one whole transaction at a time.
module axi_master_arbiter
  import axi_master_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [3:0]  IFU_ID = 4'd0,
  parameter logic [3:0]  LSU_ID = 4'd1
) (
  input  logic                clock,
  input  logic                reset,
  // IFU read
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic [7:0]          ifu_arlen,
  input  logic [2:0]          ifu_arsize,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rlast,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  // LSU read
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [7:0]          lsu_arlen,
  input  logic [2:0]          lsu_arsize,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rlast,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  // LSU write
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [2:0]          lsu_awsize,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wlast,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  // Downstream read
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic [3:0]          m_arid,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic [3:0]          m_rid,
  input  logic                m_rvalid,
  output logic                m_rready,
  // Downstream write
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic [3:0]          m_awid,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic [3:0]          m_bid,
  input  logic                m_bvalid,
  output logic                m_bready,
  // Status
  output logic                busy,
  output logic                proto_err
);

  arb_state_t state;
  logic       ar_done, aw_done, w_done;
  logic [7:0] len_q, beat_cnt;
  logic       gnt_valid, gnt_idx;
  logic       rd_ifu, rd_lsu, wr_lsu;
  logic       unused_ids;

  // Transactions are ordered by grant, so downstream IDs carry no routing information.
  assign unused_ids = ^{m_rid, m_bid};

  assign rd_ifu = (state == RD_IFU);
  assign rd_lsu = (state == RD_LSU);
  assign wr_lsu = (state == WR_LSU);
  assign busy   = (state != IDLE);

  rr_arbiter2 u_rr (
    .clock     (clock),
    .reset     (reset),
    .req       ({lsu_arvalid, ifu_arvalid}),
    .en        ((state == IDLE) && !lsu_awvalid),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Forward only the granted requester's AR; everything else stays quiet.
  always_comb begin
    m_araddr  = '0;
    m_arlen   = '0;
    m_arsize  = '0;
    m_arid    = '0;
    m_arvalid = 1'b0;
    if (rd_ifu) begin
      m_araddr  = ifu_araddr;
      m_arlen   = ifu_arlen;
      m_arsize  = ifu_arsize;
      m_arid    = IFU_ID;
      m_arvalid = ifu_arvalid & ~ar_done;
    end else if (rd_lsu) begin
      m_araddr  = lsu_araddr;
      m_arlen   = lsu_arlen;
      m_arsize  = lsu_arsize;
      m_arid    = LSU_ID;
      m_arvalid = lsu_arvalid & ~ar_done;
    end
  end

  assign m_arburst   = BURST_INCR;
  assign ifu_arready = rd_ifu & m_arready & ~ar_done;
  assign lsu_arready = rd_lsu & m_arready & ~ar_done;

  assign m_rready    = ar_done & ((rd_ifu & ifu_rready) | (rd_lsu & lsu_rready));
  assign ifu_rvalid  = rd_ifu & ar_done & m_rvalid;
  assign lsu_rvalid  = rd_lsu & ar_done & m_rvalid;
  assign ifu_rdata   = m_rdata;
  assign ifu_rresp   = m_rresp;
  assign ifu_rlast   = m_rlast;
  assign lsu_rdata   = m_rdata;
  assign lsu_rresp   = m_rresp;
  assign lsu_rlast   = m_rlast;

  assign m_awaddr    = wr_lsu ? lsu_awaddr : '0;
  assign m_awsize    = wr_lsu ? lsu_awsize : '0;
  assign m_awlen     = '0;
  assign m_awburst   = BURST_INCR;
  assign m_awid      = LSU_ID;
  assign m_awvalid   = wr_lsu & lsu_awvalid & ~aw_done;
  assign lsu_awready = wr_lsu & m_awready & ~aw_done;

  assign m_wdata     = wr_lsu ? lsu_wdata : '0;
  assign m_wstrb     = wr_lsu ? lsu_wstrb : '0;
  assign m_wlast     = wr_lsu & lsu_wlast;
  assign m_wvalid    = wr_lsu & lsu_wvalid & ~w_done;
  assign lsu_wready  = wr_lsu & m_wready & ~w_done;

  assign m_bready    = wr_lsu & aw_done & w_done & lsu_bready;
  assign lsu_bvalid  = wr_lsu & aw_done & w_done & m_bvalid;
  assign lsu_bresp   = m_bresp;

  // Transaction lock: grant in IDLE, track handshakes, release on last R beat or B.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ar_done   <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      len_q     <= '0;
      beat_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_awvalid)
            state <= WR_LSU;
          else if (gnt_valid)
            state <= (gnt_idx == LSU) ? RD_LSU : RD_IFU;
        end
        RD_IFU, RD_LSU: begin
          if (m_arvalid && m_arready) begin
            ar_done  <= 1'b1;
            len_q    <= m_arlen;
            beat_cnt <= '0;
          end
          if (m_rvalid && m_rready) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (m_rlast) begin
              if (beat_cnt != len_q)
                proto_err <= 1'b1;
              ar_done <= 1'b0;
              state   <= IDLE;
            end else if (beat_cnt == len_q) begin
              proto_err <= 1'b1;
            end
          end
        end
        WR_LSU: begin
          if (m_awvalid && m_awready)
            aw_done <= 1'b1;
          if (m_wvalid && m_wready)
            w_done <= 1'b1;
          if (m_bvalid && m_bready) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_master_arbiter.md
Name: axi_master_arbiter

Overview:
- Shares the core's single AXI4 master port between the instruction-fetch unit (read-only) and the load/store unit (read and write).
- Sits between the IFU/LSU AXI master interfaces and the SoC-facing AXI master.
- Grants one whole transaction at a time: address phase through the last R beat, or through the B response. Then it re-arbitrates.
- Read conflicts use round-robin. The LSU write path is muxed through the same lock.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Strobe width is DATA_W/8.
- IFU_ID, 4'd0, ARID driven downstream for IFU reads.
- LSU_ID, 4'd1, ARID/AWID driven downstream for LSU transactions.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- ifu_araddr/arlen/arsize/arvalid  in  ADDR_W/8/3/1  IFU read address.
- ifu_arready  out  1  IFU read address accept.
- ifu_rdata/rresp/rlast/rvalid  out  DATA_W/2/1/1  IFU read data.
- ifu_rready  in  1  IFU read data accept.
- lsu_araddr/arlen/arsize/arvalid  in  ADDR_W/8/3/1  LSU read address.
- lsu_arready  out  1  LSU read address accept.
- lsu_rdata/rresp/rlast/rvalid  out  DATA_W/2/1/1  LSU read data.
- lsu_rready  in  1  LSU read data accept.
- lsu_awaddr/awsize/awvalid  in  ADDR_W/3/1  LSU write address.
- lsu_awready  out  1  LSU write address accept.
- lsu_wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  LSU write data.
- lsu_wready  out  1  LSU write data accept.
- lsu_bresp/bvalid  out  2/1  LSU write response.
- lsu_bready  in  1  LSU write response accept.
- m_araddr/arlen/arsize/arburst/arid/arvalid  out  ADDR_W/8/3/2/4/1  downstream read address. arburst is fixed at 2'b01.
- m_arready  in  1  downstream read address accept.
- m_rdata/rresp/rlast/rid/rvalid  in  DATA_W/2/1/4/1  downstream read data.
- m_rready  out  1  downstream read data accept.
- m_awaddr/awlen/awsize/awburst/awid/awvalid  out  ADDR_W/8/3/2/4/1  downstream write address. awlen is fixed at 0 and awburst at 2'b01.
- m_awready  in  1  downstream write address accept.
- m_wdata/wstrb/wlast/wvalid  out  DATA_W/DATA_W/8/1/1  downstream write data.
- m_wready  in  1  downstream write data accept.
- m_bresp/bid/bvalid  in  2/4/1  downstream write response.
- m_bready  out  1  downstream write response accept.
- busy  out  1  high in any non-IDLE state.
- proto_err  out  1  sticky flag, set on an RLAST/beat-count mismatch.

Behaviour:
- State machine states: IDLE, RD_IFU, RD_LSU, WR_LSU.
- Reset (async): state=IDLE, rr_last=IFU, beat_cnt=0, aw_done=w_done=ar_done=0, proto_err=0. All valid/ready outputs are 0, and so is busy.
- IDLE decision (registered), evaluated in priority order:
  - lsu_awvalid goes to WR_LSU. Write beats read.
  - Else if exactly one arvalid is high, grant that requester.
  - Else if both arvalid are high, grant the requester that is not rr_last, then update rr_last.
- Arbitration latency: 1 cycle. Downstream valids assert no earlier than the cycle after the grant.
- Requesters hold their valid per AXI. Outputs must not depend combinationally on ungranted inputs.
- Read states:
  - Forward the granted AR to m_ar*, with m_arvalid = granted arvalid & ~ar_done.
  - On the AR handshake: set ar_done, latch arlen into len_q, clear beat_cnt.
  - R channel is forwarded to the granted requester only. The other requester sees rvalid=0 and arready=0.
  - Each R handshake increments beat_cnt.
  - On an R handshake with m_rlast: if beat_cnt!=len_q, set proto_err. Return to IDLE next cycle and clear ar_done.
  - A beat with beat_cnt==len_q and no m_rlast also sets proto_err. The FSM still waits for rlast.
- WR_LSU state:
  - AW and W are forwarded independently. aw_done and w_done are set on their handshakes, and each channel's valid is masked once its done flag is set.
  - AW and W may complete in either order or in the same cycle.
  - m_bready = lsu_bready while both done flags are set, else 0.
  - A B handshake returns the FSM to IDLE and clears both flags.
- Response codes (rresp/bresp, including SLVERR/DECERR) pass through unmodified. The arbiter does not retry.
- No back-to-back bypass: at least one IDLE cycle separates transactions.
- Reset asserted mid-transaction: immediate return to IDLE with all handshake outputs at 0. Downstream is reset concurrently.

Decomposition:
- Shared package holds:
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - The state enum.
  - Requester index constants: IFU=0, LSU=1.
- Sub-module: rr_arbiter2, a 2-way round-robin picker with a registered last-grant pointer.

Test Plan:
- IFU only, araddr=0x3000_0000, arlen=0, slave returns 0xDEADBEEF one cycle after AR accept -> ifu_rdata=0xDEADBEEF with rlast=1, lsu_rvalid stays 0, busy drops the cycle after the R handshake.
- IFU and LSU arvalid asserted in the same cycle, twice in a row -> first grant LSU (rr_last=IFU after reset), second grant IFU; m_arid=1 then 0.
- LSU write, addr 0x8000_0004, wstrb=4'b0011, slave accepts W two cycles before AW -> exactly one AW and one W handshake, m_bready low until both are done, lsu_bvalid seen once.
- LSU arvalid and awvalid asserted together -> write transaction first (m_awvalid=1, m_arvalid=0), read granted after B completes.
- Burst read arlen=3, slave asserts rlast on the 3rd beat -> proto_err=1 (sticky), FSM returns to IDLE.
- Reset asserted during RD_LSU after AR accept -> within the same cycle m_rready=0, busy=0, lsu_arready=0; a subsequent IFU read completes normally.
